napot_encoder: RTL and testbench

NAPOT_ENCODER -- requirements
Module: napot_encoder

---
 rtl/napot_encoder.sv | 197 +++++++++++++++++++
 tb/tb_napot_encoder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/napot_encoder.sv
// ---------------------------------------------------------------------------
// napot_encoder
//
// Turns a (base, size code k) region request into a RISC-V NAPOT pmpaddr
// value and writes it to pmpaddr<idx> through a simple CSR write port.
// Region size is 8 << k bytes.
//
// Requests are checked first. They are rejected if k > 29 or if base is not
// aligned to the region size. The trailing-ones mask is built one bit per
// cycle during ENCODE, so a request of size code k spends k cycles there.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   req_valid/ready   request handshake; req_ready is high only in IDLE
//   req_base          region base byte address
//   req_k             size code (size = 8 << k bytes), legal 0..29
//   req_idx           PMP entry index (pmpaddr0..15)
//   csr_we/addr/wdata CSR write request, held until csr_ack is sampled high
//   csr_ack           CSR write accepted
//   resp_valid/ready  response handshake
//   resp_err          request rejected; no CSR write was issued
//   resp_pmpaddr      encoded pmpaddr value (0 when resp_err = 1)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module napot_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_base,
    input  logic [4:0]  req_k,
    input  logic [3:0]  req_idx,
    output logic        csr_we,
    output logic [11:0] csr_addr,
    output logic [31:0] csr_wdata,
    input  logic        csr_ack,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_err,
    output logic [31:0] resp_pmpaddr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        ENCODE = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam logic [11:0] PMPADDR0 = 12'h3B0;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [4:0]  k_q, k_d;
    logic [3:0]  idx_q, idx_d;
    logic [31:0] mask_q, mask_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        csr_we_q, csr_we_d;
    logic [11:0] csr_addr_q, csr_addr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_pmpaddr_q, resp_pmpaddr_d;

    // Alignment mask (8 << k) - 1 is formed in 33 bits so k = 29, where the
    // region spans the whole 4 GB space, does not wrap to zero.
    logic [32:0] align_mask;
    logic        chk_err;

    assign align_mask = (33'd8 << k_q) - 33'd1;
    assign chk_err    = (k_q > 5'd29) || ((base_q & align_mask[31:0]) != 32'd0);

    // The base is aligned to 8 << k bytes whenever we get past CHECK, so
    // bits k-1..0 of base >> 2 are zero and the OR just fills them with ones.
    logic [31:0] base_word;
    assign base_word = {2'b00, base_q[31:2]};

    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        k_d            = k_q;
        idx_d          = idx_q;
        mask_d         = mask_q;
        cnt_d          = cnt_q;
        csr_we_d       = csr_we_q;
        csr_addr_d     = csr_addr_q;
        csr_wdata_d    = csr_wdata_q;
        resp_valid_d   = resp_valid_q;
        resp_err_d     = resp_err_q;
        resp_pmpaddr_d = resp_pmpaddr_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d  = req_base;
                    k_d     = req_k;
                    idx_d   = req_idx;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                mask_d = 32'd0;
                cnt_d  = 5'd0;
                if (chk_err) begin
                    state_d        = RESP;
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b1;
                    resp_pmpaddr_d = 32'd0;
                end else if (k_q == 5'd0) begin
                    // Size code 0: no trailing ones, write base >> 2 directly.
                    state_d     = WRITE;
                    csr_we_d    = 1'b1;
                    csr_addr_d  = PMPADDR0 + {8'd0, idx_q};
                    csr_wdata_d = base_word;
                end else begin
                    state_d = ENCODE;
                end
            end

            ENCODE: begin
                mask_d = {mask_q[30:0], 1'b1};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == k_q - 5'd1) begin
                    // Last shift: load the write port with the final mask so
                    // csr_wdata is registered on entry to WRITE.
                    state_d     = WRITE;
                    csr_we_d    = 1'b1;
                    csr_addr_d  = PMPADDR0 + {8'd0, idx_q};
                    csr_wdata_d = base_word | mask_d;
                end
            end

            WRITE: begin
                if (csr_ack) begin
                    state_d        = RESP;
                    csr_we_d       = 1'b0;
                    resp_valid_d   = 1'b1;
                    resp_err_d     = 1'b0;
                    resp_pmpaddr_d = csr_wdata_q;
                end
            end

            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            base_q         <= 32'd0;
            k_q            <= 5'd0;
            idx_q          <= 4'd0;
            mask_q         <= 32'd0;
            cnt_q          <= 5'd0;
            csr_we_q       <= 1'b0;
            csr_addr_q     <= 12'd0;
            csr_wdata_q    <= 32'd0;
            resp_valid_q   <= 1'b0;
            resp_err_q     <= 1'b0;
            resp_pmpaddr_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            k_q            <= k_d;
            idx_q          <= idx_d;
            mask_q         <= mask_d;
            cnt_q          <= cnt_d;
            csr_we_q       <= csr_we_d;
            csr_addr_q     <= csr_addr_d;
            csr_wdata_q    <= csr_wdata_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_pmpaddr_q <= resp_pmpaddr_d;
        end
    end

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign req_ready    = (state_q == IDLE) && rst_n;
    assign csr_we       = csr_we_q;
    assign csr_addr     = csr_addr_q;
    assign csr_wdata    = csr_wdata_q;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_pmpaddr = resp_pmpaddr_q;

endmodule

// File: tb/tb_napot_encoder.sv
// ---------------------------------------------------------------------------
// tb_napot_encoder
//
// Scoreboard bench for napot_encoder. The stimulus task pushes the expected
// result of each accepted request into exp_q. Independent processes behave
// as the CSR file and the response consumer, and a negedge monitor compares
// whatever the DUT presents against the front of the queue.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_napot_encoder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_base;
    logic [4:0]  req_k;
    logic [3:0]  req_idx;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ack;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_err;
    logic [31:0] resp_pmpaddr;

    napot_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_base     (req_base),
        .req_k        (req_k),
        .req_idx      (req_idx),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_ack      (csr_ack),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_err     (resp_err),
        .resp_pmpaddr (resp_pmpaddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        err;
        logic [31:0] pmp;
        logic [11:0] addr;
        int          lat;
        int          ack_dly;
        int          rdy_dly;
        int          acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: straight from the region arithmetic.
    function automatic exp_t model(bit [31:0] base, int k, int idx, int ad, int rd);
        exp_t e;
        longint unsigned size;
        size      = 64'd8 << k;
        e.err     = (k > 29) || ((64'(base) % size) != 0);
        e.pmp     = e.err ? 32'd0 : 32'((64'(base) / 4) + ((64'd1 << k) - 1));
        e.addr    = 12'(12'h3B0 + idx);
        e.lat     = e.err ? 1 : (2 + k + ad);
        e.ack_dly = ad;
        e.rdy_dly = rd;
        e.acc_cyc = 0;
        return e;
    endfunction

    // CSR file: acks after ack_dly cycles of csr_we; random noise otherwise.
    int wcnt = 0;
    always @(negedge clk) begin
        if (csr_we) begin
            csr_ack = (exp_q.size() == 0) || (wcnt >= exp_q[0].ack_dly);
            wcnt++;
        end else begin
            wcnt    = 0;
            csr_ack = 1'($urandom_range(0, 1));
        end
    end

    // Response consumer: takes the result after rdy_dly cycles of resp_valid.
    int rcnt = 0;
    always @(negedge clk) begin
        if (resp_valid) begin
            resp_ready = (exp_q.size() == 0) || (rcnt >= exp_q[0].rdy_dly);
            rcnt++;
        end else begin
            rcnt       = 0;
            resp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Retire the scoreboard entry on the response handshake edge.
    always @(posedge clk) begin
        if (rst_n && resp_valid && resp_ready && exp_q.size() > 0)
            void'(exp_q.pop_front());
    end

    // Monitor
    logic        prev_we = 1'b0;
    logic        prev_rv = 1'b0;
    logic [11:0] we_addr;
    logic [31:0] we_data;
    logic        rv_err;
    logic [31:0] rv_pmp;
    int          we_cnt = 0, we_need = 1, rv_cnt = 0, rv_need = 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_csr_we", csr_we, 0);
            chk("rst_resp_valid", resp_valid, 0);
            prev_we = 1'b0;
            prev_rv = 1'b0;
        end else begin
            if (csr_we) begin
                chk("write_req_ready", req_ready, 0);
                if (!prev_we) begin
                    we_addr = csr_addr;
                    we_data = csr_wdata;
                    we_cnt  = 1;
                    we_need = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_csr_we", csr_we, 0);
                    end else begin
                        e = exp_q[0];
                        if (e.err) chk("csr_we_on_err", csr_we, 0);
                        else begin
                            chk("csr_addr", csr_addr, e.addr);
                            chk("csr_wdata", csr_wdata, e.pmp);
                        end
                        we_need = e.ack_dly + 1;
                    end
                end else begin
                    we_cnt++;
                    chk("csr_addr_stable", csr_addr, we_addr);
                    chk("csr_wdata_stable", csr_wdata, we_data);
                end
            end else if (prev_we) begin
                chk("csr_we_cycles", we_cnt, we_need);
            end

            if (resp_valid) begin
                chk("resp_req_ready", req_ready, 0);
                if (!prev_rv) begin
                    rv_err  = resp_err;
                    rv_pmp  = resp_pmpaddr;
                    rv_cnt  = 1;
                    rv_need = 1;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp_valid", resp_valid, 0);
                    end else begin
                        e = exp_q[0];
                        chk("latency", cyc - e.acc_cyc, e.lat);
                        chk("resp_err", resp_err, e.err);
                        chk("resp_pmpaddr", resp_pmpaddr, e.pmp);
                        rv_need = e.rdy_dly + 1;
                    end
                end else begin
                    rv_cnt++;
                    chk("resp_err_stable", resp_err, rv_err);
                    chk("resp_pmpaddr_stable", resp_pmpaddr, rv_pmp);
                end
            end else if (prev_rv) begin
                chk("resp_valid_cycles", rv_cnt, rv_need);
            end

            prev_we = csr_we;
            prev_rv = resp_valid;
        end
    end

    task automatic send(bit [31:0] base, int k, int idx, int ad, int rd, bit wait_done);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1);
            return;
        end
        req_base  = base;
        req_k     = 5'(k);
        req_idx   = 4'(idx);
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        e         = model(base, k, idx, ad, rd);
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        req_valid = 1'b0;
        $display("req base=0x%08h k=%0d idx=%0d ack_dly=%0d rdy_dly=%0d -> err=%0d pmpaddr=0x%08h",
                 base, k, idx, ad, rd, e.err, e.pmp);
        if (wait_done) begin
            n = 0;
            while (exp_q.size() != 0 && n < 500) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                chk("response_timeout", exp_q.size(), 0);
                exp_q.delete();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int          k;
        bit [31:0]   base;
        longint unsigned amask;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_base   = 32'd0;
        req_k      = 5'd0;
        req_idx    = 4'd0;
        csr_ack    = 1'b0;
        resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_csr_addr", csr_addr, 0);
        chk("reset_csr_wdata", csr_wdata, 0);
        chk("reset_resp_err", resp_err, 0);
        chk("reset_resp_pmpaddr", resp_pmpaddr, 0);

        // Directed cases
        send(32'h8000_0000, 0,  0, 0, 0, 1);
        send(32'h8000_0000, 9,  5, 0, 0, 1);
        send(32'h8000_0100, 9,  2, 0, 0, 1);
        send(32'h1234_5678, 30, 1, 0, 0, 1);
        send(32'h0000_0000, 31, 1, 0, 0, 1);
        send(32'h0000_0000, 29, 7, 0, 0, 1);
        send(32'h8000_0000, 29, 7, 0, 0, 1);
        send(32'h8000_0000, 9,  3, 3, 4, 1);
        send(32'h0000_0008, 0, 15, 1, 2, 1);

        // Reset in the middle of ENCODE aborts the request silently.
        send(32'h8000_0000, 20, 1, 0, 0, 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1);
        chk("post_reset_csr_we", csr_we, 0);
        chk("post_reset_resp_valid", resp_valid, 0);
        repeat (30) @(negedge clk);
        send(32'h8000_0000, 20, 1, 0, 0, 1);

        // Randomised requests
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) k = $urandom_range(25, 31);
            else                           k = $urandom_range(0, 20);
            base = $urandom;
            if ($urandom_range(0, 3) != 0 && k <= 29) begin
                amask = (64'd8 << k) - 1;
                base  = base & ~(32'(amask));
            end
            send(base, k, $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 1);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
